pipelined_adder: RTL



---
 rtl/pipelined_adder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract with carry/borrow in; the carry chain is cut into STAGES registered chunks.
// Optional build macro PIPELINED_ADDER_SAT_EN: saturate sum on signed overflow, choosing the limit by the sign of a.
module pipelined_adder #(
    parameter int WIDTH  = 20,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (WIDTH < 2 || STAGES < 2 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder: need WIDTH >= 2, STAGES >= 2 and WIDTH divisible by STAGES");
    end

    function automatic logic [CW:0] chunk_add(
        input logic [CW-1:0] x,
        input logic [CW-1:0] y,
        input logic          ci
    );
        chunk_add = {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, ci};
    endfunction

    logic             adv_s;
    logic [WIDTH-1:0] bx_s;
    logic             carry0_s;

    logic [WIDTH-1:0] src_a_s  [STAGES];
    logic [WIDTH-1:0] src_bx_s [STAGES];
    logic [WIDTH-1:0] src_ps_s [STAGES];
    logic             src_c_s  [STAGES];
    logic             src_v_s  [STAGES];

    logic [WIDTH-1:0] a_q  [LAST];
    logic [WIDTH-1:0] a_d  [LAST];
    logic [WIDTH-1:0] bx_q [LAST];
    logic [WIDTH-1:0] bx_d [LAST];
    logic [WIDTH-1:0] ps_q [LAST];
    logic [WIDTH-1:0] ps_d [LAST];
    logic             c_q  [LAST];
    logic             c_d  [LAST];
    logic             v_q  [LAST];
    logic             v_d  [LAST];

    logic [CW:0]      fin_s;
    logic [WIDTH-1:0] sum_raw_s;
    logic [WIDTH-1:0] sum_d;
    logic             c_out_d;
    logic             ovf_d;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             out_valid_q;

    // A single global enable: the whole pipe moves only when the output slot can drain.
    assign adv_s    = ~out_valid_q | out_ready;
    assign in_ready = adv_s;

    // Subtraction is a + ~b + ~c_in, so the borrow in becomes an inverted carry in.
    assign bx_s     = sub ? ~b : b;
    assign carry0_s = c_in ^ sub;

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

    // Inputs seen by each stage: conditioned operands for stage 0, previous register otherwise.
    always_comb begin
        src_a_s[0]  = a;
        src_bx_s[0] = bx_s;
        src_ps_s[0] = {WIDTH{1'b0}};
        src_c_s[0]  = carry0_s;
        src_v_s[0]  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a_s[k]  = a_q[k-1];
            src_bx_s[k] = bx_q[k-1];
            src_ps_s[k] = ps_q[k-1];
            src_c_s[k]  = c_q[k-1];
            src_v_s[k]  = v_q[k-1];
        end
    end

    // Stage k resolves chunk k; operands and finished partial sums ride along unchanged.
    always_comb begin
        for (int k = 0; k < LAST; k++) begin
            a_d[k]  = src_a_s[k];
            bx_d[k] = src_bx_s[k];
            ps_d[k] = src_ps_s[k];
            {c_d[k], ps_d[k][k*CW +: CW]} =
                chunk_add(src_a_s[k][k*CW +: CW], src_bx_s[k][k*CW +: CW], src_c_s[k]);
            v_d[k]  = src_v_s[k];
        end
    end

    // Last chunk, flags and optional saturation.
    always_comb begin
        fin_s     = chunk_add(src_a_s[LAST][LAST*CW +: CW], src_bx_s[LAST][LAST*CW +: CW],
                              src_c_s[LAST]);
        sum_raw_s = src_ps_s[LAST];
        sum_raw_s[LAST*CW +: CW] = fin_s[CW-1:0];
        c_out_d   = fin_s[CW];
        // The MSB sum bit is a ^ bx ^ carry-in, so the carry into the MSB falls out by XOR.
        ovf_d     = src_a_s[LAST][WIDTH-1] ^ src_bx_s[LAST][WIDTH-1] ^ sum_raw_s[WIDTH-1] ^ fin_s[CW];
`ifdef PIPELINED_ADDER_SAT_EN
        if (ovf_d) begin
            sum_d = src_a_s[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sum_d = sum_raw_s;
        end
`else
        sum_d = sum_raw_s;
`endif
    end

    // Intermediate stage registers: all shift together on adv, all hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAST; k++) begin
                a_q[k]  <= {WIDTH{1'b0}};
                bx_q[k] <= {WIDTH{1'b0}};
                ps_q[k] <= {WIDTH{1'b0}};
                c_q[k]  <= 1'b0;
                v_q[k]  <= 1'b0;
            end
        end else if (adv_s) begin
            for (int k = 0; k < LAST; k++) begin
                a_q[k]  <= a_d[k];
                bx_q[k] <= bx_d[k];
                ps_q[k] <= ps_d[k];
                c_q[k]  <= c_d[k];
                v_q[k]  <= v_d[k];
            end
        end
    end

    // Output slot: valid follows the last stage; data only changes for a real result so bubbles keep it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= {WIDTH{1'b0}};
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv_s) begin
            out_valid_q <= src_v_s[LAST];
            if (src_v_s[LAST]) begin
                sum_q   <= sum_d;
                c_out_q <= c_out_d;
                ovf_q   <= ovf_d;
            end
        end
    end

endmodule
